fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives the instruction-memory address and holds the IF/ID pipeline register.
- Consumes the PC-select encoding produced by the ID-stage control decoder (0 sequential, 1 j/jal, 2 jr/jalr) and the branch resolution from EX.
- Applies stall and flush, then presents the fetched instruction to ID, where the decoder reads OpCode/Funct from it.
- No branch delay slot: every redirect squashes the younger fetched instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush (sll $0,$0,0).
- IRQ_VECTOR, 32'h8000_0004, interrupt handler address (used only with FETCH_IRQ_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_stall  in  1  load-use hazard; hold PC and IF/ID.
- i_id_pcsrc  in  2  decoder PC select for the ID instruction: 0 seq, 1 j/jal, 2 jr/jalr, 3 reserved (treated as 0).
- i_id_rs_data  in  32  forwarded rs value, used as the jr/jalr target.
- i_ex_branch_taken  in  1  branch in EX resolved taken.
- i_ex_branch_target  in  32  branch target from EX.
- imem_addr  out  32  instruction-memory address (combinational read memory).
- imem_rdata  in  32  instruction word at imem_addr, same cycle.
- o_pc  out  32  current PC register.
- o_ifid_instr  out  32  IF/ID instruction.
- o_ifid_pc4  out  32  IF/ID PC+4.
- o_ifid_valid  out  1  IF/ID holds a real instruction.
- irq  in  1  level interrupt request (FETCH_IRQ_EN only).
- o_epc  out  32  saved exception PC (FETCH_IRQ_EN only).

Behaviour:
- Reset (asynchronous, active-high):
  - PC = RESET_PC.
  - o_ifid_instr = NOP_INSTR, o_ifid_pc4 = 0, o_ifid_valid = 0.
  - o_epc = 0.
- imem_addr = PC, combinational. Fetch latency is 1 cycle: the word addressed in cycle N appears on o_ifid_instr in cycle N+1.
- pc4 = PC + 4, 32-bit with wrap-around modulo 2^32 (no trap).
- i_id_pcsrc is qualified by o_ifid_valid; when valid = 0 the ID jump is ignored.
- Next-state priority, highest first:
  1. i_ex_branch_taken:
     - PC <= i_ex_branch_target.
     - IF/ID flushed: instr = NOP_INSTR, valid = 0, pc4 = 0.
     - Overrides i_stall, because the EX branch is older than the stalled ID instruction.
  2. i_stall: PC and IF/ID hold all values; any ID jump is deferred until the stall drops.
  3. Qualified ID jump:
     - pcsrc 1: PC <= {o_ifid_pc4[31:28], o_ifid_instr[25:0], 2'b00}.
     - pcsrc 2: PC <= i_id_rs_data, with no alignment check.
     - IF/ID flushed in both cases.
  4. Sequential: PC <= pc4; IF/ID <= {imem_rdata, pc4, valid = 1}.
- Reset asserted mid-stall or mid-redirect: reset wins immediately; pending redirects are lost.
- Two-cycle penalty for a taken branch, one-cycle penalty for a jump.

Optional Feature:
- FETCH_IRQ_EN defined:
  - irq is accepted in a cycle only when all of these hold: no EX branch taken, no stall, no qualified ID jump, and PC[31] = 0 (kernel mode masks interrupts).
  - On acceptance: o_epc <= PC (the squashed IF instruction), PC <= IRQ_VECTOR, IF/ID flushed.
  - irq is level-sensitive; while it is not accepted it stays pending.
- FETCH_IRQ_EN undefined:
  - irq and o_epc ports are absent.
  - Behaviour is exactly the base priority list.

Decomposition:
- Shared package mips_pkg: PCSRC_SEQ = 2'd0, PCSRC_J = 2'd1, PCSRC_JR = 2'd2, NOP_INSTR, IRQ_VECTOR, and a typedef for the 32-bit word.
- One natural sub-module, fetch_next_pc: combinational priority mux producing the next PC and a flush flag.
- PC and IF/ID registers stay in fetch_unit.

Test Plan:
1. Reset release, no hazards, imem returns the address as data → imem_addr 0,4,8…; o_ifid_instr lags by 1 cycle; valid = 1 from the second cycle.
2. ID holds j with index 0x0000010, ifid_pc4 = 0x0000_0014 → next PC = 0x0000_0040, IF/ID becomes NOP with valid = 0 for 1 cycle.
3. jr with i_id_rs_data = 0x0000_0100 under i_stall for 2 cycles → PC and IF/ID hold for 2 cycles, then PC = 0x100.
4. i_ex_branch_taken with target 0x200 in the same cycle as i_stall and an ID jump → PC = 0x200, IF/ID flushed, jump discarded.
5. PC = 0xFFFF_FFFC sequential → PC wraps to 0x0000_0000, o_ifid_pc4 = 0.
6. FETCH_IRQ_EN defined:
   - irq at PC = 0x30 → o_epc = 0x30, PC = 0x8000_0004, IF/ID flushed.
   - irq held at PC[31] = 1 → no redirect.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end:
//   word_t      - 32-bit machine word
//   PCSRC_*     - PC-select encoding produced by the ID-stage control decoder
//   NOP_INSTR   - bubble injected into IF/ID on a flush (sll $0,$0,0)
//   IRQ_VECTOR  - interrupt handler entry point
//   next_sel_e  - which source won the next-PC priority decision
//   jump_target - j/jal target formation from the delay-free PC+4 region
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] PCSRC_SEQ  = 2'd0;
  localparam logic [1:0] PCSRC_J    = 2'd1;
  localparam logic [1:0] PCSRC_JR   = 2'd2;
  localparam logic [1:0] PCSRC_RSVD = 2'd3;

  localparam word_t RESET_PC   = 32'h0000_0000;
  localparam word_t NOP_INSTR  = 32'h0000_0000;
  localparam word_t IRQ_VECTOR = 32'h8000_0004;

  // Outcome of the next-PC priority mux. SEL_HOLD keeps PC and IF/ID,
  // SEL_SEQ advances normally, every other value redirects and flushes.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_IRQ    = 3'd4
  } next_sel_e;

  // j/jal: keep the 256 MB region of the instruction after the jump.
  function automatic word_t jump_target(input logic [3:0]  region,
                                        input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// ---------------------------------------------------------------------------
// fetch_next_pc
// Combinational priority mux for the fetch stage. Highest priority first:
//   EX taken branch > stall > qualified ID jump > interrupt > sequential.
// The interrupt input is only ever driven high when FETCH_IRQ_EN is defined
// in the enclosing fetch_unit; otherwise it is tied low and that leg is dead.
//
// Ports:
//   pc_i                 current PC register
//   pc4_i                PC + 4 (wrapping)
//   ifid_valid_i         IF/ID holds a real instruction (qualifies pcsrc)
//   pc4_region_i         IF/ID PC+4 bits [31:28]
//   j_index_i            IF/ID instruction bits [25:0]
//   stall_i              load-use stall
//   id_pcsrc_i           decoder PC select for the ID instruction
//   id_rs_data_i         forwarded rs, jr/jalr target
//   ex_branch_taken_i    EX branch resolved taken
//   ex_branch_target_i   EX branch target
//   irq_i                interrupt request (already feature-gated)
//   next_pc_o            PC value for the next cycle
//   sel_o                which source won
// ---------------------------------------------------------------------------
module fetch_next_pc
  import mips_pkg::*;
#(
  parameter word_t IRQ_VEC = mips_pkg::IRQ_VECTOR
) (
  input  word_t       pc_i,
  input  word_t       pc4_i,
  input  logic        ifid_valid_i,
  input  logic [3:0]  pc4_region_i,
  input  logic [25:0] j_index_i,
  input  logic        stall_i,
  input  logic [1:0]  id_pcsrc_i,
  input  word_t       id_rs_data_i,
  input  logic        ex_branch_taken_i,
  input  word_t       ex_branch_target_i,
  input  logic        irq_i,
  output word_t       next_pc_o,
  output next_sel_e   sel_o
);

  logic id_jump;

  // A bubble in IF/ID carries no decoder result, so its pcsrc is ignored.
  // The reserved encoding falls through to sequential.
  assign id_jump = ifid_valid_i &&
                   ((id_pcsrc_i == PCSRC_J) || (id_pcsrc_i == PCSRC_JR));

  always_comb begin
    next_pc_o = pc4_i;
    sel_o     = SEL_SEQ;
    if (ex_branch_taken_i) begin
      // The EX branch is older than the stalled ID instruction, so it wins.
      next_pc_o = ex_branch_target_i;
      sel_o     = SEL_BRANCH;
    end else if (stall_i) begin
      // Any ID jump is simply re-evaluated once the stall drops.
      next_pc_o = pc_i;
      sel_o     = SEL_HOLD;
    end else if (id_jump) begin
      sel_o = SEL_JUMP;
      if (id_pcsrc_i == PCSRC_J) begin
        next_pc_o = jump_target(pc4_region_i, j_index_i);
      end else begin
        next_pc_o = id_rs_data_i;
      end
    end else if (irq_i && !pc_i[31]) begin
      // Upper half of the address space is kernel mode: interrupts masked.
      next_pc_o = IRQ_VEC;
      sel_o     = SEL_IRQ;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
// the combinational instruction memory and holds the IF/ID register. There is
// no branch delay slot: every redirect replaces the younger fetched word in
// IF/ID with a NOP bubble (valid = 0).
//
// Configuration macro: FETCH_IRQ_EN adds the irq input and o_epc output and
// a level-sensitive interrupt redirect with the lowest redirect priority.
//
// Stall/flush contract: i_stall holds PC and IF/ID unchanged for that cycle;
// i_ex_branch_taken overrides a stall in the same cycle; a jump presented on
// i_id_pcsrc while stalled is not lost, because the jump stays in IF/ID and
// is re-presented by the decoder once the stall drops.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   i_stall               load-use hazard hold
//   i_id_pcsrc            decoder PC select (0 seq, 1 j, 2 jr, 3 = seq)
//   i_id_rs_data          jr/jalr target
//   i_ex_branch_taken     EX branch taken
//   i_ex_branch_target    EX branch target
//   imem_addr, imem_rdata instruction memory (same-cycle read)
//   o_pc                  PC register
//   o_ifid_instr/pc4/valid IF/ID register
//   irq, o_epc            interrupt request / saved PC (FETCH_IRQ_EN only)
// ---------------------------------------------------------------------------
module fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC   = mips_pkg::RESET_PC,
  parameter word_t NOP_INSTR  = mips_pkg::NOP_INSTR,
  parameter word_t IRQ_VECTOR = mips_pkg::IRQ_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic [1:0]  i_id_pcsrc,
  input  logic [31:0] i_id_rs_data,
  input  logic        i_ex_branch_taken,
  input  logic [31:0] i_ex_branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
`ifdef FETCH_IRQ_EN
  output logic        o_ifid_valid,
  input  logic        irq,
  output logic [31:0] o_epc
`else
  output logic        o_ifid_valid
`endif
);

  word_t     pc_q, pc_d;
  word_t     pc4;
  word_t     ifid_instr_q, ifid_instr_d;
  word_t     ifid_pc4_q, ifid_pc4_d;
  logic      ifid_valid_q, ifid_valid_d;
  logic      irq_req;
  word_t     next_pc;
  next_sel_e sel;

  // Natural 32-bit overflow gives the required wrap from 0xFFFF_FFFC to 0.
  assign pc4 = pc_q + 32'd4;

`ifdef FETCH_IRQ_EN
  assign irq_req = irq;
`else
  assign irq_req = 1'b0;
`endif

  fetch_next_pc #(
    .IRQ_VEC (IRQ_VECTOR)
  ) u_next_pc (
    .pc_i               (pc_q),
    .pc4_i              (pc4),
    .ifid_valid_i       (ifid_valid_q),
    .pc4_region_i       (ifid_pc4_q[31:28]),
    .j_index_i          (ifid_instr_q[25:0]),
    .stall_i            (i_stall),
    .id_pcsrc_i         (i_id_pcsrc),
    .id_rs_data_i       (i_id_rs_data),
    .ex_branch_taken_i  (i_ex_branch_taken),
    .ex_branch_target_i (i_ex_branch_target),
    .irq_i              (irq_req),
    .next_pc_o          (next_pc),
    .sel_o              (sel)
  );

  always_comb begin
    pc_d         = next_pc;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    case (sel)
      SEL_HOLD: ;
      SEL_SEQ: begin
        ifid_instr_d = imem_rdata;
        ifid_pc4_d   = pc4;
        ifid_valid_d = 1'b1;
      end
      default: begin
        // Any redirect squashes the word fetched this cycle.
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = 32'd0;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_IRQ_EN
  word_t epc_q, epc_d;

  // The instruction at PC was fetched but squashed; it resumes after the handler.
  assign epc_d = (sel == SEL_IRQ) ? pc_q : epc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q <= 32'd0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign o_epc = epc_q;
`endif

  assign imem_addr    = pc_q;
  assign o_pc         = pc_q;
  assign o_ifid_instr = ifid_instr_q;
  assign o_ifid_pc4   = ifid_pc4_q;
  assign o_ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit. The instruction memory model
// returns its own address unless an override word is selected for a vector.
// Each vector is driven on the falling edge and checked 1 ns after the
// following rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall;
  logic [1:0]  i_id_pcsrc;
  logic [31:0] i_id_rs_data;
  logic        i_ex_branch_taken;
  logic [31:0] i_ex_branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_ifid_instr;
  logic [31:0] o_ifid_pc4;
  logic        o_ifid_valid;
`ifdef FETCH_IRQ_EN
  logic        irq;
  logic [31:0] o_epc;
`endif

  logic        ovr_en;
  logic [31:0] ovr_word;

  int n_checks = 0;
  int n_fail   = 0;

  // ---- clock --------------------------------------------------------------
  always #5 clk = ~clk;

  // ---- instruction memory model -------------------------------------------
  assign imem_rdata = ovr_en ? ovr_word : imem_addr;

  fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .i_stall            (i_stall),
    .i_id_pcsrc         (i_id_pcsrc),
    .i_id_rs_data       (i_id_rs_data),
    .i_ex_branch_taken  (i_ex_branch_taken),
    .i_ex_branch_target (i_ex_branch_target),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .o_pc               (o_pc),
    .o_ifid_instr       (o_ifid_instr),
    .o_ifid_pc4         (o_ifid_pc4),
`ifdef FETCH_IRQ_EN
    .o_ifid_valid       (o_ifid_valid),
    .irq                (irq),
    .o_epc              (o_epc)
`else
    .o_ifid_valid       (o_ifid_valid)
`endif
  );

  // ---- vector table -------------------------------------------------------
  typedef struct {
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] rs;
    logic        br;
    logic [31:0] tgt;
    logic        ovr;
    logic [31:0] ovr_w;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic [1:0] ps,
                              input logic [31:0] rs, input logic br,
                              input logic [31:0] tgt, input logic ov,
                              input logic [31:0] ow, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] p4,
                              input logic vl);
    vec_t v;
    v.stall = st; v.pcsrc = ps; v.rs = rs; v.br = br; v.tgt = tgt;
    v.ovr = ov; v.ovr_w = ow;
    v.e_pc = pc; v.e_instr = ins; v.e_pc4 = p4; v.e_valid = vl;
    return v;
  endfunction

  // ---- scoreboard ---------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] p4,
                             input logic vl);
    check({tag, " pc"},    o_pc, pc);
    check({tag, " imem"},  imem_addr, pc);
    check({tag, " instr"}, o_ifid_instr, ins);
    check({tag, " pc4"},   o_ifid_pc4, p4);
    check({tag, " valid"}, {31'd0, o_ifid_valid}, {31'd0, vl});
  endtask

  // ---- driver -------------------------------------------------------------
  task automatic clear_inputs();
    i_stall = 1'b0; i_id_pcsrc = 2'd0; i_id_rs_data = 32'd0;
    i_ex_branch_taken = 1'b0; i_ex_branch_target = 32'd0;
    ovr_en = 1'b0; ovr_word = 32'd0;
`ifdef FETCH_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  task automatic drive(input vec_t v);
    i_stall = v.stall; i_id_pcsrc = v.pcsrc; i_id_rs_data = v.rs;
    i_ex_branch_taken = v.br; i_ex_branch_target = v.tgt;
    ovr_en = v.ovr; ovr_word = v.ovr_w;
  endtask

  initial begin
    // j with index 0x10; j with index 0x3FFFFFF
    //                 stall pcsrc rs            br    tgt           ov    ow             pc            instr         pc4           valid
    vecs[0]  = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h04,       32'h00,       32'h04,       1'b1);
    vecs[1]  = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h08,       32'h04,       32'h08,       1'b1);
    vecs[2]  = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h0C,       32'h08,       32'h0C,       1'b1);
    vecs[3]  = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h10,       32'h0C,       32'h10,       1'b1);
    vecs[4]  = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h0800_0010, 32'h14,      32'h0800_0010, 32'h14,      1'b1);
    vecs[5]  = mk(1'b0, 2'd1, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h40,       32'h00,       32'h00,       1'b0);
    vecs[6]  = mk(1'b0, 2'd1, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       1'b1);
    vecs[7]  = mk(1'b1, 2'd2, 32'h100,     1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       1'b1);
    vecs[8]  = mk(1'b1, 2'd2, 32'h100,     1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       1'b1);
    vecs[9]  = mk(1'b0, 2'd2, 32'h100,     1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      32'h00,       32'h00,       1'b0);
    vecs[10] = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      32'h100,      32'h104,      1'b1);
    vecs[11] = mk(1'b1, 2'd1, 32'h0,       1'b1, 32'h200,      1'b0, 32'h0,        32'h200,      32'h00,       32'h00,       1'b0);
    vecs[12] = mk(1'b0, 2'd2, 32'h300,     1'b0, 32'h0,        1'b0, 32'h0,        32'h204,      32'h200,      32'h204,      1'b1);
    vecs[13] = mk(1'b0, 2'd3, 32'h300,     1'b0, 32'h0,        1'b0, 32'h0,        32'h208,      32'h204,      32'h208,      1'b1);
    vecs[14] = mk(1'b0, 2'd0, 32'h0,       1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       32'hFFFF_FFFC, 32'h00,      32'h00,       1'b0);
    vecs[15] = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h00,       32'hFFFF_FFFC, 32'h00,      1'b1);
    vecs[16] = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h04,       32'h00,       32'h04,       1'b1);
    vecs[17] = mk(1'b0, 2'd2, 32'h103,     1'b0, 32'h0,        1'b0, 32'h0,        32'h103,      32'h00,       32'h00,       1'b0);
    vecs[18] = mk(1'b0, 2'd0, 32'h0,       1'b1, 32'h7000_0010, 1'b0, 32'h0,       32'h7000_0010, 32'h00,      32'h00,       1'b0);
    vecs[19] = mk(1'b0, 2'd0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h0BFF_FFFF, 32'h7000_0014, 32'h0BFF_FFFF, 32'h7000_0014, 1'b1);
    vecs[20] = mk(1'b0, 2'd1, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        32'h7FFF_FFFC, 32'h00,      32'h00,       1'b0);

    // ---- reset ------------------------------------------------------------
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_IRQ_EN
    check("reset epc", o_epc, 32'h0);
`endif
    reset = 1'b0;

    // ---- table ------------------------------------------------------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                  vecs[i].e_pc4, vecs[i].e_valid);
      @(negedge clk);
    end
    clear_inputs();

    // ---- async reset during a stalled, pending branch ---------------------
    i_stall = 1'b1;
    i_ex_branch_taken = 1'b1;
    i_ex_branch_target = 32'h500;
    #2 reset = 1'b1;
    #1;
    check_state("async rst", 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("rst hold pc", o_pc, 32'h0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post rst", 32'h4, 32'h0, 32'h4, 1'b1);

`ifdef FETCH_IRQ_EN
    // ---- interrupt --------------------------------------------------------
    @(negedge clk);
    i_ex_branch_taken = 1'b1;
    i_ex_branch_target = 32'h30;
    @(posedge clk);
    #1;
    check("irq setup pc", o_pc, 32'h30);
    @(negedge clk);
    i_ex_branch_taken = 1'b0;
    irq = 1'b1;
    i_stall = 1'b1;
    @(posedge clk);
    #1;
    check("irq stalled pc", o_pc, 32'h30);
    check("irq stalled epc", o_epc, 32'h0);
    @(negedge clk);
    i_stall = 1'b0;
    @(posedge clk);
    #1;
    check_state("irq take", 32'h8000_0004, 32'h0, 32'h0, 1'b0);
    check("irq epc", o_epc, 32'h30);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_state("irq masked", 32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 1'b1);
    check("irq masked epc", o_epc, 32'h30);
    @(negedge clk);
    clear_inputs();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
